// File: rtl/counter_pkg.sv
// Shared counter definitions: MODO encodings and the WIDTH/DOWN_STEP legality check.
// COUNTER_PARAMS_LEGAL(w, s) is true for 2 <= w <= 32 and 1 <= s <= 2**w-1.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

`define COUNTER_PARAMS_LEGAL(w, s) \
  (((w) >= 2) && ((w) <= 32) && ((s) >= 1) && (longint'(s) < (longint'(1) << (w))))

package counter_pkg;

  typedef enum logic [1:0] {
    MODO_UP      = 2'b00,
    MODO_DN      = 2'b01,
    MODO_DN_STEP = 2'b10,
    MODO_LOAD    = 2'b11
  } modo_e;

endpackage

`endif

// File: rtl/counter_next_val.sv
// Next-count datapath: WIDTH+1-bit add/subtract whose carry/borrow bit is the wrap flag.
// With COUNTER_SAT_EN defined, a wrapping result is clamped to all-ones (up) or zero (down).
module counter_next_val
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int unsigned DOWN_STEP = 3
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(DOWN_STEP);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    q_next = q;
    wrap   = 1'b0;
    case (modo)
      MODO_UP: begin
        sum    = {1'b0, q} + (WIDTH+1)'(1);
        q_next = sum[WIDTH-1:0];
        wrap   = sum[WIDTH];
`ifdef COUNTER_SAT_EN
        if (wrap) q_next = '1;
`endif
      end
      MODO_DN: begin
        sum    = {1'b0, q} - (WIDTH+1)'(1);
        q_next = sum[WIDTH-1:0];
        wrap   = sum[WIDTH];
`ifdef COUNTER_SAT_EN
        if (wrap) q_next = '0;
`endif
      end
      MODO_DN_STEP: begin
        sum    = {1'b0, q} - {1'b0, STEP};
        q_next = sum[WIDTH-1:0];
        wrap   = sum[WIDTH];
`ifdef COUNTER_SAT_EN
        if (wrap) q_next = '0;
`endif
      end
      MODO_LOAD: begin
        q_next = d;
        wrap   = 1'b0;
      end
      // Unknown MODO holds the count without flagging a wrap.
      default: begin
        q_next = q;
        wrap   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/counter_param_sync.sv
// Parametrised up/down/step/load counter with registered one-cycle RCO on wrap (or clamp).
// Define COUNTER_SAT_EN at compile time for saturating instead of wrapping arithmetic.
module counter_param_sync
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int unsigned DOWN_STEP = 3
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  if (!(`COUNTER_PARAMS_LEGAL(WIDTH, DOWN_STEP))) begin : g_param_err
    $error("counter_param_sync: illegal WIDTH/DOWN_STEP");
  end

  logic [WIDTH-1:0] q_next;
  logic             wrap;

  counter_next_val #(
    .WIDTH     (WIDTH),
    .DOWN_STEP (DOWN_STEP)
  ) u_next_val (
    .q      (Q),
    .modo   (MODO),
    .d      (D),
    .q_next (q_next),
    .wrap   (wrap)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else if (ENB) begin
      Q   <= q_next;
      RCO <= wrap;
    end else begin
      RCO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_param_sync.sv
// Scoreboard bench for counter_param_sync: directed vectors on 16-bit/step-3 and 4-bit/step-5
// instances, plus a 4-bit/step-3 instance checked against an integer reference model.
module tb_counter_param_sync;
  import counter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] d16;
  logic [3:0]  d4;
  logic [15:0] q16;
  logic        rco16;
  logic [3:0]  q4s, q4;
  logic        rco4s, rco4;

  always #5 clk = ~clk;

  counter_param_sync #(.WIDTH(16), .DOWN_STEP(3)) u_dut16 (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .MODO(modo), .D(d16), .Q(q16), .RCO(rco16));
  counter_param_sync #(.WIDTH(4), .DOWN_STEP(5)) u_dut4s5 (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .MODO(modo), .D(d4), .Q(q4s), .RCO(rco4s));
  counter_param_sync #(.WIDTH(4), .DOWN_STEP(3)) u_dut4 (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .MODO(modo), .D(d4), .Q(q4), .RCO(rco4));

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] q;
    logic        rco;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act_q, input logic act_rco,
                     input logic [15:0] exp_q, input logic exp_rco);
    checks++;
    if (act_q !== exp_q || act_rco !== exp_rco) begin
      failures++;
      $display("FAIL %s: got Q=%h RCO=%b, want Q=%h RCO=%b", name, act_q, act_rco, exp_q, exp_rco);
    end
  endtask

  task automatic push(input string name, input int sel, input logic [15:0] q, input logic rco);
    sb.push_back('{name, sel, q, rco});
  endtask

  task automatic drive(input logic e_i, input logic [1:0] m_i, input logic [15:0] d16_i,
                       input logic [3:0] d4_i);
    @(negedge clk);
    enb  = e_i;
    modo = m_i;
    d16  = d16_i;
    d4   = d4_i;
  endtask

  // Independent integer model of the 4-bit, step-3 counter.
  function automatic void model4(input logic [3:0] q, input logic e_i, input logic [1:0] m_i,
                                 input logic [3:0] dd, output logic [3:0] nq, output logic rco);
    int v;
    v   = int'(q);
    rco = 1'b0;
    if (e_i) begin
      case (m_i)
        2'b00: v = v + 1;
        2'b01: v = v - 1;
        2'b10: v = v - 3;
        default: v = int'(dd);
      endcase
      rco = (v > 15) || (v < 0);
`ifdef COUNTER_SAT_EN
      if (v > 15) v = 15;
      if (v < 0) v = 0;
`else
      if (v > 15) v = v - 16;
      if (v < 0) v = v + 16;
`endif
    end
    nq = 4'(v);
  endfunction

  // Monitor: every entry queued before an edge is due one edge later.
  always begin
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       chk(e.name, q16, rco16, e.q, e.rco);
        1:       chk(e.name, {12'h000, q4s}, rco4s, e.q, e.rco);
        default: chk(e.name, {12'h000, q4}, rco4, e.q, e.rco);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mq, nq;
    logic       mr, re;
    logic [1:0] rm;
    logic [3:0] rd;

    rst_n = 1'b0;
    enb   = 1'b0;
    modo  = MODO_UP;
    d16   = '0;
    d4    = '0;
    #2;
    chk("reset_init", q16, rco16, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 1; i <= 5; i++) begin
      drive(1'b1, MODO_UP, 16'h0, 4'h0);
      push("pre_reset_up", 0, 16'(i), 1'b0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", q16, rco16, 16'h0000, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, MODO_UP, 16'h0, 4'h0);
      push("reset_hold", 0, 16'h0000, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

`ifndef COUNTER_SAT_EN
    drive(1'b1, MODO_LOAD, 16'hFFFE, 4'h0); push("load_fffe", 0, 16'hFFFE, 1'b0);
    drive(1'b1, MODO_UP,   16'h0, 4'h0);    push("up_ffff",   0, 16'hFFFF, 1'b0);
    drive(1'b1, MODO_UP,   16'h0, 4'h0);    push("up_wrap",   0, 16'h0000, 1'b1);
    drive(1'b1, MODO_UP,   16'h0, 4'h0);    push("up_after",  0, 16'h0001, 1'b0);

    drive(1'b1, MODO_LOAD, 16'h0001, 4'h0); push("load_0001", 0, 16'h0001, 1'b0);
    drive(1'b1, MODO_DN,   16'h0, 4'h0);    push("dn_zero",   0, 16'h0000, 1'b0);
    drive(1'b1, MODO_DN,   16'h0, 4'h0);    push("dn_wrap",   0, 16'hFFFF, 1'b1);
    drive(1'b1, MODO_DN,   16'h0, 4'h0);    push("dn_after",  0, 16'hFFFE, 1'b0);

    drive(1'b1, MODO_LOAD, 16'h0004, 4'h2);
    push("load_0004", 0, 16'h0004, 1'b0);
    push("w4_load_2", 1, 16'h0002, 1'b0);
    drive(1'b1, MODO_DN_STEP, 16'h0, 4'h0);
    push("step_0001", 0, 16'h0001, 1'b0);
    push("w4_step_wrap", 1, 16'h000D, 1'b1);
    drive(1'b1, MODO_DN_STEP, 16'h0, 4'h0);
    push("step_wrap", 0, 16'hFFFE, 1'b1);
    push("w4_step_8", 1, 16'h0008, 1'b0);
`else
    drive(1'b1, MODO_LOAD, 16'hFFFF, 4'h0); push("sat_load_ffff", 0, 16'hFFFF, 1'b0);
    drive(1'b1, MODO_UP,   16'h0, 4'h0);    push("sat_up_1",      0, 16'hFFFF, 1'b1);
    drive(1'b1, MODO_UP,   16'h0, 4'h0);    push("sat_up_2",      0, 16'hFFFF, 1'b1);
    drive(1'b1, MODO_LOAD, 16'h0000, 4'h0); push("sat_load_0",    0, 16'h0000, 1'b0);
    drive(1'b1, MODO_DN,   16'h0, 4'h0);    push("sat_dn",        0, 16'h0000, 1'b1);
    drive(1'b1, MODO_LOAD, 16'h0002, 4'h2);
    push("sat_load_0002", 0, 16'h0002, 1'b0);
    push("sat_w4_load_2", 1, 16'h0002, 1'b0);
    drive(1'b1, MODO_DN_STEP, 16'h0, 4'h0);
    push("sat_step", 0, 16'h0000, 1'b1);
    push("sat_w4_step", 1, 16'h0000, 1'b1);
`endif

    drive(1'b1, MODO_LOAD, 16'h1234, 4'h0); push("load_1234", 0, 16'h1234, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b0, 2'(i), 16'hAAAA, 4'hA);
      push("enb_hold", 0, 16'h1234, 1'b0);
    end

    mq = 4'h0;
    drive(1'b1, MODO_LOAD, 16'h0, mq);
    push("rand_seed", 2, 16'h0000, 1'b0);
    for (int unsigned i = 0; i < 1000; i++) begin
      re = ($urandom_range(0, 4) != 0);
      rm = 2'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      model4(mq, re, rm, rd, nq, mr);
      drive(re, rm, 16'h0, rd);
      push("rand_w4", 2, {12'h000, nq}, mr);
      mq = nq;
    end

    drive(1'b0, MODO_UP, 16'h0, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
